// File: rtl/bcd_converter_if.sv
// Handshake/result bundle between a producer (multiplier) and bcd_converter.
// Optional macro BCD_BLANK_LEADING_ZERO_EN adds the digit_en signal.
interface bcd_converter_if #(
  parameter int IN_WIDTH = 12,
  parameter int DIGITS   = 4
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_in;
  logic                  ready;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0]     digit_en;

  modport master (output start, bin_in,
                  input  ready, valid, bcd_out, overflow, digit_en);
  modport slave  (input  start, bin_in,
                  output ready, valid, bcd_out, overflow, digit_en);
`else
  modport master (output start, bin_in,
                  input  ready, valid, bcd_out, overflow);
  modport slave  (input  start, bin_in,
                  output ready, valid, bcd_out, overflow);
`endif
endinterface

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional macro BCD_BLANK_LEADING_ZERO_EN adds a registered leading-zero blank mask.
module bcd_converter #(
  parameter int IN_WIDTH  = 12,
  parameter int DIGITS    = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_converter_if.slave   bus
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [IN_WIDTH-1:0]   bin_shift;
  logic [BW-1:0]         bcd_scr;
  logic [BW-1:0]         bcd_adj;
  logic [BW-1:0]         bcd_next;
  logic                  ovf_scr;
  logic                  carry;
  logic [CNT_WIDTH-1:0]  cnt;

  // Add-3 on every digit >= 5, then shift the top binary bit into the BCD scratch.
  always_comb begin
    bcd_adj = bcd_scr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_scr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_scr[4*i +: 4] + 4'd3;
    end
    carry    = bcd_adj[BW-1];
    bcd_next = {bcd_adj[BW-2:0], bin_shift[IN_WIDTH-1]};
  end

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0] en_next;
  logic              any_nz;

  always_comb begin
    en_next = '0;
    any_nz  = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      any_nz = any_nz | (|bcd_next[4*(DIGITS-1-j) +: 4]);
      en_next[DIGITS-1-j] = any_nz;
    end
    en_next[0] = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bin_shift    <= '0;
      bcd_scr      <= '0;
      ovf_scr      <= 1'b0;
      cnt          <= '0;
      bus.ready    <= 1'b1;
      bus.valid    <= 1'b0;
      bus.bcd_out  <= '0;
      bus.overflow <= 1'b0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
      bus.digit_en <= DIGITS'(1);
`endif
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_shift <= bus.bin_in;
            bcd_scr   <= '0;
            ovf_scr   <= 1'b0;
            cnt       <= CNT_WIDTH'(IN_WIDTH - 1);
            bus.ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bin_shift <= {bin_shift[IN_WIDTH-2:0], 1'b0};
          bcd_scr   <= bcd_next;
          ovf_scr   <= ovf_scr | carry;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.bcd_out  <= bcd_next;
            bus.overflow <= ovf_scr | carry;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            bus.digit_en <= en_next;
`endif
            bus.valid    <= 1'b1;
            bus.ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: 4-digit and 3-digit instances share stimulus and
// are checked every cycle against an arithmetic model, plus literal checks.
module tb_bcd_converter;

  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] bin_in;

  int n_pass  = 0;
  int n_total = 0;

  bcd_converter_if #(.IN_WIDTH(IW), .DIGITS(4)) if4 ();
  bcd_converter_if #(.IN_WIDTH(IW), .DIGITS(3)) if3 ();

  assign if4.start  = start;
  assign if4.bin_in = bin_in;
  assign if3.start  = start;
  assign if3.bin_in = bin_in;

  bcd_converter #(.IN_WIDTH(IW), .DIGITS(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));
  bcd_converter #(.IN_WIDTH(IW), .DIGITS(3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] en_model(input int v, input int d);
    logic [31:0] r = 32'd1;
    int m = v % pow10(d);
    for (int i = 0; i < d; i++)
      if (m / pow10(i) != 0) r[i] = 1'b1;
    return r;
  endfunction

  // Reference model: a conversion accepted at cycle c delivers its value at c+IW.
  int cyc     = 0;
  bit m_busy  = 1'b0;
  bit m_valid = 1'b0;
  int m_done  = 0;
  int m_pend  = 0;
  int m_val   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_val   = 0;
      if (clk) cyc++;
    end else begin
      bit pre_busy;
      cyc++;
      pre_busy = m_busy;
      m_valid  = 1'b0;
      if (pre_busy && cyc == m_done) begin
        m_val   = m_pend;
        m_valid = 1'b1;
        m_busy  = 1'b0;
      end
      if (!pre_busy && start) begin
        m_busy = 1'b1;
        m_done = cyc + IW;
        m_pend = int'(bin_in);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("ready4",   32'(if4.ready),    32'(!m_busy));
      check("valid4",   32'(if4.valid),    32'(m_valid));
      check("bcd4",     32'(if4.bcd_out),  to_bcd(m_val, 4));
      check("ovf4",     32'(if4.overflow), 32'(m_val >= 10000));
      check("ready3",   32'(if3.ready),    32'(!m_busy));
      check("valid3",   32'(if3.valid),    32'(m_valid));
      check("bcd3",     32'(if3.bcd_out),  to_bcd(m_val % 1000, 3));
      check("ovf3",     32'(if3.overflow), 32'(m_val >= 1000));
`ifdef BCD_BLANK_LEADING_ZERO_EN
      check("digit_en4", 32'(if4.digit_en), en_model(m_val, 4));
      check("digit_en3", 32'(if3.digit_en), en_model(m_val, 3));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until valid is seen (bounded); returns cycles waited.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!if4.valid && n < 40);
  endtask

  // Leaves the bench in the valid cycle so the next call starts back-to-back.
  task automatic run_conv(input int v, input logic [15:0] e4, input logic [11:0] e3,
                          input logic o3, input logic [3:0] en4);
    int n;
    start  = 1'b1;
    bin_in = IW'(v);
    tick();
    start  = 1'b0;
    bin_in = IW'($urandom_range(0, 4095));
    check("ready_drop", 32'(if4.ready), 32'd0);
    wait_valid(n);
    check("latency", 32'(n), 32'd12);
    check("lit_bcd4", 32'(if4.bcd_out), 32'(e4));
    check("lit_bcd3", 32'(if3.bcd_out), 32'(e3));
    check("lit_ovf3", 32'(if3.overflow), 32'(o3));
`ifdef BCD_BLANK_LEADING_ZERO_EN
    check("lit_digit_en", 32'(if4.digit_en), 32'(en4));
`else
    if (en4 == 4'hx) $display("unreachable");
`endif
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    check("rst_ready", 32'(if4.ready), 32'd1);
    check("rst_valid", 32'(if4.valid), 32'd0);
    check("rst_bcd",   32'(if4.bcd_out), 32'd0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    check("rst_digit_en", 32'(if4.digit_en), 32'b0001);
`endif
    rst_n = 1'b1;
    tick();

    run_conv(3825, 16'h3825, 12'h825, 1'b1, 4'b1111);
    run_conv(0,    16'h0000, 12'h000, 1'b0, 4'b0001);
    run_conv(4095, 16'h4095, 12'h095, 1'b1, 4'b1111);
    tick();

    // Start ignored while busy.
    start = 1'b1; bin_in = IW'(9);
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; bin_in = IW'(1234);
    tick();
    start = 1'b0;
    check("busy_ready", 32'(if4.ready), 32'd0);
    wait_valid(n);
    check("busy_latency", 32'(n), 32'd7);
    check("busy_bcd", 32'(if4.bcd_out), 32'h0009);
    tick();

    // Reset mid-conversion.
    start = 1'b1; bin_in = IW'(2048);
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(if4.ready), 32'd1);
    check("abort_bcd",   32'(if4.bcd_out), 32'd0);
    check("abort_valid", 32'(if4.valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_conv(1001, 16'h1001, 12'h001, 1'b1, 4'b1111);
    run_conv(999,  16'h0999, 12'h999, 1'b0, 4'b0111);
    run_conv(1000, 16'h1000, 12'h000, 1'b1, 4'b1111);
    run_conv(45,   16'h0045, 12'h045, 1'b0, 4'b0011);
    run_conv(3008, 16'h3008, 12'h008, 1'b1, 4'b1111);
    run_conv(700,  16'h0700, 12'h700, 1'b0, 4'b0111);

    // Random traffic, spurious starts, input churn and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      start  = ($urandom_range(0, 3) == 0);
      bin_in = IW'($urandom_range(0, 4095));
      rst_n  = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double dabble) downstream of the sequential multiplier.
- Consumes the registered multiplier product (default 12 bits: 8x4 operands, max 255*15 = 3825) and produces packed BCD digits for the seven-segment display driver.
- One bit per clock, with a start/ready/valid handshake, so the multiplier's display state can trigger a conversion.

Parameters:
- IN_WIDTH, 12, width of the binary input (matches the multiplier product width).
- DIGITS, 4, number of BCD output digits; bcd_out is 4*DIGITS bits.
- CNT_WIDTH, 4, width of the iteration counter; must satisfy 2^CNT_WIDTH >= IN_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request conversion of bin_in; sampled only while ready=1.
- bin_in  input  IN_WIDTH  unsigned binary value; latched on the accepted start edge.
- ready  output  1  converter idle, start will be accepted.
- valid  output  1  one-cycle pulse: bcd_out/overflow updated with a new result.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; holds until next result.
- overflow  output  1  value did not fit in DIGITS digits; qualified with bcd_out.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, ready=1, valid=0, bcd_out=0, overflow=0.
  - Internal shift register and counter cleared.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - ready=1.
  - On a clock edge with start=1: latch bin_in into the binary shift register, clear the BCD scratch register and the overflow scratch bit, load counter=IN_WIDTH-1, go to SHIFT.
  - ready drops to 0 the following cycle.
- SHIFT (ready=0), one iteration per edge:
  - First, each scratch digit >= 5 gets +3 (all digits in parallel).
  - Then {bcd_scratch, bin_shift} shifts left by 1.
  - The bit shifted out of the top BCD digit is ORed into the overflow scratch.
  - If counter != 0: decrement the counter.
  - If counter == 0: write the post-shift BCD into bcd_out and the overflow scratch (including this iteration's carry-out) into overflow, pulse valid=1, go to IDLE (ready=1 the next cycle).
- Latency: accept edge E0, shift edges E1..E_IN_WIDTH. valid is high in exactly the one cycle following edge E_IN_WIDTH; default latency is 12 cycles.
- Throughput: start may be asserted in the same cycle valid is high; it is accepted. Back-to-back conversions run every IN_WIDTH+1 cycles.
- start while ready=0 is ignored: no queueing, bin_in not re-sampled, the running conversion is undisturbed.
- bin_in changing after the accept edge has no effect.
- bcd_out and overflow change only on the valid edge. Between results they hold their last value, including during a new conversion.
- Digit adjust uses 4-bit unsigned compare/add. A digit never exceeds 9 after a shift while overflow=0.
- Overflow example: IN_WIDTH=12, DIGITS=3, input 1000 -> overflow=1; bcd_out equals the low 3 decimal digits (0x000).
- Reset mid-conversion aborts immediately: state=IDLE, no valid pulse, bcd_out=0.
- Simultaneous start and rst_n low: reset wins.

Optional Feature:
- Macro BCD_BLANK_LEADING_ZERO_EN.
- When defined:
  - Adds output port digit_en [DIGITS-1:0], registered and updated on the valid edge together with bcd_out.
  - digit_en[i]=1 if digit i is nonzero or any higher digit is nonzero.
  - digit_en[0] is forced to 1, so the units digit is always shown.
  - Reset value: only bit 0 set.
  - The display driver uses digit_en to blank leading zeros.
- When undefined: port absent, no extra logic; the display shows all DIGITS digits.

Test Plan:
1. Reset, then start with bin_in=3825 (0xEF1) -> ready=0 next cycle; exactly 12 cycles after the accept edge valid=1 for one cycle; bcd_out=0x3825, overflow=0; ready=1.
2. bin_in=0, then bin_in=4095 back-to-back, second start asserted in the valid cycle of the first:
   - first result bcd_out=0x0000;
   - second accepted with no idle gap, bcd_out=0x4095 after 12 more cycles;
   - two valid pulses total.
3. Start with bin_in=9, then pulse start with bin_in=1234 at cycle 5 of the conversion -> second start ignored; one valid with bcd_out=0x0009; ready stays 0 until the conversion ends.
4. Start with bin_in=2048, deassert rst_n at cycle 6 -> ready=1, bcd_out=0, no valid pulse; a following conversion of 1001 gives 0x1001.
5. Instance with DIGITS=3: bin_in=999 -> bcd_out=0x999, overflow=0; bin_in=1000 -> bcd_out=0x000, overflow=1.
6. With BCD_BLANK_LEADING_ZERO_EN defined: 45 -> digit_en=4'b0011; 0 -> 4'b0001; 3008 -> 4'b1111; 700 -> 4'b0111. The reset value is checked as 4'b0001.
